// File: rtl/br_csr_issue_queue_pkg.sv
// Shared types and constants for the branch/CSR issue queue.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package br_csr_issue_queue_pkg;

  localparam int SLOT_W     = 4;
  localparam int IQ_DEPTH   = 1 << SLOT_W;
  localparam int TAG_W      = 6;
  localparam int UOP_W      = 64;
  localparam int WAKE_PORTS = 2;

  // Slot order the free-slot queue hands out after reset or flush.
  localparam logic [SLOT_W-1:0] FL_RST_SLOT0 = 4'd2;
  localparam logic [SLOT_W-1:0] FL_RST_SLOT1 = 4'd6;
  localparam logic [SLOT_W-1:0] FL_RST_SLOT2 = 4'd10;
  localparam logic [SLOT_W-1:0] FL_RST_SLOT3 = 4'd14;
  localparam logic [SLOT_W-1:0] FL_RST_SLOT4 = 4'd0;

  typedef struct packed {
    logic             valid;
    logic             rdy1;
    logic             rdy2;
    logic [TAG_W-1:0] tag1;
    logic [TAG_W-1:0] tag2;
    logic [UOP_W-1:0] uop;
  } brcsr_iq_entry_t;

  // True when any valid wakeup port broadcasts the given tag.
  function automatic logic wake_hit(
    input logic [WAKE_PORTS-1:0]       vld,
    input logic [WAKE_PORTS*TAG_W-1:0] tags,
    input logic [TAG_W-1:0]            tag
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKE_PORTS; k++) begin
      if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/br_csr_issue_queue_select.sv
// Picks one ready entry: lowest index, or oldest when BRCSR_IQ_AGE_SEL_EN is defined.
// Latency: combinational grant; the age matrix updates on the allocation edge.
// Backpressure: none; the caller decides whether the grant is consumed.
//
// Ports: Clk/Rest/Flush clock, async reset, flush; alloc_vld/alloc_slot allocation
// (already gated by flush); cand candidate vector; grant one-hot, grant_idx encoded,
// grant_vld any grant.
module brcsr_iq_select
  import br_csr_issue_queue_pkg::*;
#(
  parameter int NUM_ENT = IQ_DEPTH,
  parameter int IDX_W   = SLOT_W
) (
  input  logic               Clk,
  input  logic               Rest,
  input  logic               Flush,
  input  logic               alloc_vld,
  input  logic [IDX_W-1:0]   alloc_slot,
  input  logic [NUM_ENT-1:0] cand,
  output logic [NUM_ENT-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [NUM_ENT-1:0] pick_vec;

`ifdef BRCSR_IQ_AGE_SEL_EN
  // age[i][j] = 1 means entry j was allocated before entry i.
  logic [NUM_ENT-1:0] age [NUM_ENT];

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int i = 0; i < NUM_ENT; i++) age[i] <= '0;
    end else if (Flush) begin
      for (int i = 0; i < NUM_ENT; i++) age[i] <= '0;
    end else if (alloc_vld) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        for (int j = 0; j < NUM_ENT; j++) begin
          if (IDX_W'(i) == alloc_slot)      age[i][j] <= (IDX_W'(j) != alloc_slot);
          else if (IDX_W'(j) == alloc_slot) age[i][j] <= 1'b0;
        end
      end
    end
  end

  // A candidate is eligible only if no other candidate is older.
  always_comb begin
    pick_vec = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      pick_vec[i] = cand[i] & ~(|(age[i] & cand));
    end
  end
`else
  assign pick_vec = cand;

  logic unused_sel_in;
  assign unused_sel_in = ^{Clk, Rest, Flush, alloc_vld, alloc_slot};
`endif

  // Lowest-index pick; with the age matrix this only breaks impossible ties.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

  assign grant_vld = |pick_vec;

endmodule

// File: rtl/br_csr_issue_queue.sv
// Branch/CSR issue queue: holds renamed uops until both sources wake, issues one per cycle.
// Latency: alloc edge N -> IssueValid after N+1 -> FreeWable pulse after N+2.
// Backpressure: IssueReady low holds the issue register; entries keep waiting.
//
// Ports: Clk, Rest (async active-low); Alloc* dispatch write into slot AllocSlot;
// Wake* two tag broadcast ports (port 0 in low bits); Issue* issue register with
// IssueReady handshake; FreeWable/FreeDin registered slot return to the free-slot
// queue; Flush synchronous clear; IqCount live entry count.
// Optional: BRCSR_IQ_AGE_SEL_EN selects oldest-first instead of lowest-index.
module br_csr_issue_queue #(
  parameter int SLOT_W   = br_csr_issue_queue_pkg::SLOT_W,
  parameter int IQ_DEPTH = br_csr_issue_queue_pkg::IQ_DEPTH,
  parameter int TAG_W    = br_csr_issue_queue_pkg::TAG_W,
  parameter int UOP_W    = br_csr_issue_queue_pkg::UOP_W
) (
  input  logic                 Clk,
  input  logic                 Rest,
  input  logic                 AllocValid,
  input  logic [SLOT_W-1:0]    AllocSlot,
  input  logic [UOP_W-1:0]     AllocUop,
  input  logic [TAG_W-1:0]     AllocSrc1Tag,
  input  logic                 AllocSrc1Rdy,
  input  logic [TAG_W-1:0]     AllocSrc2Tag,
  input  logic                 AllocSrc2Rdy,
  input  logic [br_csr_issue_queue_pkg::WAKE_PORTS-1:0]       WakeValid,
  input  logic [br_csr_issue_queue_pkg::WAKE_PORTS*TAG_W-1:0] WakeTag,
  input  logic                 IssueReady,
  output logic                 IssueValid,
  output logic [UOP_W-1:0]     IssueUop,
  output logic [SLOT_W-1:0]    IssueSlot,
  output logic                 FreeWable,
  output logic [SLOT_W-1:0]    FreeDin,
  input  logic                 Flush,
  output logic [SLOT_W:0]      IqCount
);
  import br_csr_issue_queue_pkg::*;

  brcsr_iq_entry_t       ent [IQ_DEPTH];
  logic [IQ_DEPTH-1:0]   cand;
  logic [IQ_DEPTH-1:0]   grant;
  logic [SLOT_W-1:0]     grant_idx;
  logic                  grant_vld;
  logic                  load;
  logic                  alloc_en;
  logic                  ret_pend;
  logic                  alloc_rdy1;
  logic                  alloc_rdy2;

  assign alloc_en = AllocValid & ~Flush;

  // Entries are sourced only from registered state, so a uop written this
  // cycle cannot be picked until the following cycle.
  always_comb begin
    cand = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      cand[i] = ent[i].valid & ent[i].rdy1 & ent[i].rdy2;
    end
  end

  brcsr_iq_select #(
    .NUM_ENT (IQ_DEPTH),
    .IDX_W   (SLOT_W)
  ) u_select (
    .Clk        (Clk),
    .Rest       (Rest),
    .Flush      (Flush),
    .alloc_vld  (alloc_en),
    .alloc_slot (AllocSlot),
    .cand       (cand),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  assign load = grant_vld & (~IssueValid | IssueReady);

  // A wakeup landing in the allocation cycle would otherwise be lost.
  assign alloc_rdy1 = AllocSrc1Rdy | wake_hit(WakeValid, WakeTag, AllocSrc1Tag);
  assign alloc_rdy2 = AllocSrc2Rdy | wake_hit(WakeValid, WakeTag, AllocSrc2Tag);

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int i = 0; i < IQ_DEPTH; i++) ent[i].valid <= 1'b0;
    end else if (Flush) begin
      for (int i = 0; i < IQ_DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        if (ent[i].valid && wake_hit(WakeValid, WakeTag, ent[i].tag1)) ent[i].rdy1 <= 1'b1;
        if (ent[i].valid && wake_hit(WakeValid, WakeTag, ent[i].tag2)) ent[i].rdy2 <= 1'b1;
        if (load && grant[i]) ent[i].valid <= 1'b0;
      end
      if (AllocValid) begin
        ent[AllocSlot] <= '{valid: 1'b1,
                           rdy1:  alloc_rdy1,
                           rdy2:  alloc_rdy2,
                           tag1:  AllocSrc1Tag,
                           tag2:  AllocSrc2Tag,
                           uop:   AllocUop};
      end
    end
  end

  // Issue register, slot return pipeline and occupancy counter. The slot
  // return trails the load by one edge; IssueSlot still holds the loaded
  // slot on that edge even if a new load happens simultaneously.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      IssueValid <= 1'b0;
      IssueUop   <= '0;
      IssueSlot  <= '0;
      ret_pend   <= 1'b0;
      FreeWable  <= 1'b0;
      FreeDin    <= '0;
      IqCount    <= '0;
    end else if (Flush) begin
      // The free-slot queue rebuilds its list on Flush, so nothing is returned.
      IssueValid <= 1'b0;
      ret_pend   <= 1'b0;
      FreeWable  <= 1'b0;
      IqCount    <= '0;
    end else begin
      if (load) begin
        IssueValid <= 1'b1;
        IssueUop   <= ent[grant_idx].uop;
        IssueSlot  <= grant_idx;
      end else if (IssueValid && IssueReady) begin
        IssueValid <= 1'b0;
      end
      ret_pend  <= load;
      FreeWable <= ret_pend;
      if (ret_pend) FreeDin <= IssueSlot;
      IqCount <= IqCount + (SLOT_W+1)'(AllocValid) - (SLOT_W+1)'(load);
    end
  end

  // Dispatch must only use slots handed out by the free-slot queue.
  logic alloc_clash;
  assign alloc_clash = alloc_en & ent[AllocSlot].valid;

  a_alloc_free_slot: assert property (@(posedge Clk) disable iff (!Rest) !alloc_clash);

endmodule

// File: tb/tb_br_csr_issue_queue.sv
module tb_br_csr_issue_queue;

  logic        Clk;
  logic        Rest;
  logic        AllocValid;
  logic [3:0]  AllocSlot;
  logic [63:0] AllocUop;
  logic [5:0]  AllocSrc1Tag;
  logic        AllocSrc1Rdy;
  logic [5:0]  AllocSrc2Tag;
  logic        AllocSrc2Rdy;
  logic [1:0]  WakeValid;
  logic [11:0] WakeTag;
  logic        IssueReady;
  logic        IssueValid;
  logic [63:0] IssueUop;
  logic [3:0]  IssueSlot;
  logic        FreeWable;
  logic [3:0]  FreeDin;
  logic        Flush;
  logic [4:0]  IqCount;

  br_csr_issue_queue dut (
    .Clk          (Clk),
    .Rest         (Rest),
    .AllocValid   (AllocValid),
    .AllocSlot    (AllocSlot),
    .AllocUop     (AllocUop),
    .AllocSrc1Tag (AllocSrc1Tag),
    .AllocSrc1Rdy (AllocSrc1Rdy),
    .AllocSrc2Tag (AllocSrc2Tag),
    .AllocSrc2Rdy (AllocSrc2Rdy),
    .WakeValid    (WakeValid),
    .WakeTag      (WakeTag),
    .IssueReady   (IssueReady),
    .IssueValid   (IssueValid),
    .IssueUop     (IssueUop),
    .IssueSlot    (IssueSlot),
    .FreeWable    (FreeWable),
    .FreeDin      (FreeDin),
    .Flush        (Flush),
    .IqCount      (IqCount)
  );

  typedef struct {
    logic [3:0]  slot;
    logic [63:0] uop;
    int          cyc;
  } exp_t;

  exp_t exp_iss[$];
  exp_t exp_free[$];
  exp_t e_iss;
  exp_t e_free;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

`ifdef BRCSR_IQ_AGE_SEL_EN
  localparam logic [3:0]  D_FIRST   = 4'd14;
  localparam logic [63:0] D_FIRST_U = 64'hD000_0000_0000_000E;
  localparam logic [3:0]  D_SECOND  = 4'd0;
  localparam logic [63:0] D_SECOND_U = 64'hD000_0000_0000_0000;
`else
  localparam logic [3:0]  D_FIRST   = 4'd0;
  localparam logic [63:0] D_FIRST_U = 64'hD000_0000_0000_0000;
  localparam logic [3:0]  D_SECOND  = 4'd14;
  localparam logic [63:0] D_SECOND_U = 64'hD000_0000_0000_000E;
`endif

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic alloc(input logic [3:0] slot, input logic [63:0] uop,
                       input logic [5:0] t1, input logic r1,
                       input logic [5:0] t2, input logic r2);
    AllocValid   = 1'b1;
    AllocSlot    = slot;
    AllocUop     = uop;
    AllocSrc1Tag = t1;
    AllocSrc1Rdy = r1;
    AllocSrc2Tag = t2;
    AllocSrc2Rdy = r2;
    tick();
    AllocValid   = 1'b0;
  endtask

  // Monitor: every accepted issue and every slot return is matched against
  // the scoreboard, including the cycle in which it appears.
  always @(negedge Clk) begin
    if (Rest) begin
      if (IssueValid && IssueReady) begin
        if (exp_iss.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL iss_unexpected: got slot %0d, want no issue (cyc %0d)", IssueSlot, cyc);
        end else begin
          e_iss = exp_iss.pop_front();
          chk("iss_slot", 64'(IssueSlot), 64'(e_iss.slot));
          chk("iss_uop", IssueUop, e_iss.uop);
          chk("iss_cyc", 64'(cyc), 64'(e_iss.cyc));
        end
      end
      if (FreeWable) begin
        if (exp_free.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL free_unexpected: got slot %0d, want no return (cyc %0d)", FreeDin, cyc);
        end else begin
          e_free = exp_free.pop_front();
          chk("free_slot", 64'(FreeDin), 64'(e_free.slot));
          chk("free_cyc", 64'(cyc), 64'(e_free.cyc));
        end
      end
    end
  end

  initial begin
    int c;
    int w;
    Rest = 1'b0; AllocValid = 1'b0; AllocSlot = '0; AllocUop = '0;
    AllocSrc1Tag = '0; AllocSrc1Rdy = 1'b0; AllocSrc2Tag = '0; AllocSrc2Rdy = 1'b0;
    WakeValid = '0; WakeTag = '0; IssueReady = 1'b0; Flush = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_issue_valid", 64'(IssueValid), 64'd0);
    chk("rst_issue_uop",   IssueUop,        64'd0);
    chk("rst_issue_slot",  64'(IssueSlot),  64'd0);
    chk("rst_free_wable",  64'(FreeWable),  64'd0);
    chk("rst_free_din",    64'(FreeDin),    64'd0);
    chk("rst_iq_count",    64'(IqCount),    64'd0);
    Rest = 1'b1;
    repeat (2) tick();

    // A: slot 2 ready at alloc, minimum latency and slot return
    IssueReady = 1'b1;
    c = cyc;
    exp_iss.push_back('{slot: 4'd2, uop: 64'hA000_0000_0000_0002, cyc: c + 2});
    exp_free.push_back('{slot: 4'd2, uop: 64'd0, cyc: c + 3});
    alloc(4'd2, 64'hA000_0000_0000_0002, 6'd1, 1'b1, 6'd2, 1'b1);
    chk("a_count_after_alloc", 64'(IqCount), 64'd1);
    tick();
    chk("a_count_after_issue", 64'(IqCount), 64'd0);
    repeat (3) tick();

    // B: slot 6 waits on tag 5; an invalid port-0 broadcast must not wake it
    alloc(4'd6, 64'hB000_0000_0000_0006, 6'd5, 1'b0, 6'd0, 1'b1);
    WakeValid = 2'b00; WakeTag = {6'd5, 6'd5};
    tick();
    WakeTag = '0;
    tick();
    chk("b_count_waiting", 64'(IqCount), 64'd1);
    w = cyc;
    exp_iss.push_back('{slot: 4'd6, uop: 64'hB000_0000_0000_0006, cyc: w + 2});
    exp_free.push_back('{slot: 4'd6, uop: 64'd0, cyc: w + 3});
    WakeValid = 2'b10; WakeTag = {6'd5, 6'd0};
    tick();
    WakeValid = 2'b00; WakeTag = '0;
    repeat (4) tick();

    // C: same-cycle wakeup bypass on source 2
    c = cyc;
    exp_iss.push_back('{slot: 4'd10, uop: 64'hC000_0000_0000_000A, cyc: c + 2});
    exp_free.push_back('{slot: 4'd10, uop: 64'd0, cyc: c + 3});
    WakeValid = 2'b01; WakeTag = {6'd0, 6'd9};
    alloc(4'd10, 64'hC000_0000_0000_000A, 6'd3, 1'b1, 6'd9, 1'b0);
    WakeValid = 2'b00; WakeTag = '0;
    repeat (4) tick();

    // D: slots 14 then 0 woken together, issue stalled for three cycles
    IssueReady = 1'b0;
    alloc(4'd14, 64'hD000_0000_0000_000E, 6'd20, 1'b0, 6'd0, 1'b1);
    alloc(4'd0,  64'hD000_0000_0000_0000, 6'd20, 1'b0, 6'd0, 1'b1);
    w = cyc;
    exp_iss.push_back('{slot: D_FIRST,  uop: D_FIRST_U,  cyc: w + 5});
    exp_iss.push_back('{slot: D_SECOND, uop: D_SECOND_U, cyc: w + 6});
    exp_free.push_back('{slot: D_FIRST,  uop: 64'd0, cyc: w + 3});
    exp_free.push_back('{slot: D_SECOND, uop: 64'd0, cyc: w + 7});
    WakeValid = 2'b01; WakeTag = {6'd0, 6'd20};
    tick();
    WakeValid = 2'b00; WakeTag = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("d_stall_valid", 64'(IssueValid), 64'd1);
      chk("d_stall_slot",  64'(IssueSlot),  64'(D_FIRST));
      chk("d_stall_uop",   IssueUop,        D_FIRST_U);
    end
    chk("d_count_stalled", 64'(IqCount), 64'd1);
    tick();
    IssueReady = 1'b1;
    repeat (4) tick();

    // E: flush with four waiting entries, a held issue and a same-cycle alloc
    IssueReady = 1'b0;
    c = cyc;
    exp_free.push_back('{slot: 4'd2, uop: 64'd0, cyc: c + 3});
    alloc(4'd2,  64'hE000_0000_0000_0002, 6'd1,  1'b1, 6'd0, 1'b1);
    alloc(4'd6,  64'hE000_0000_0000_0006, 6'd30, 1'b0, 6'd0, 1'b1);
    alloc(4'd10, 64'hE000_0000_0000_000A, 6'd30, 1'b0, 6'd0, 1'b1);
    alloc(4'd14, 64'hE000_0000_0000_000E, 6'd30, 1'b0, 6'd0, 1'b1);
    alloc(4'd0,  64'hE000_0000_0000_0000, 6'd30, 1'b0, 6'd0, 1'b1);
    chk("e_count_before_flush", 64'(IqCount), 64'd4);
    chk("e_held_slot", 64'(IssueSlot), 64'd2);
    Flush = 1'b1;
    WakeValid = 2'b11; WakeTag = {6'd30, 6'd30};
    alloc(4'd7, 64'hE000_0000_0000_0007, 6'd1, 1'b1, 6'd0, 1'b1);
    Flush = 1'b0;
    WakeValid = 2'b00; WakeTag = '0;
    chk("e_count_after_flush", 64'(IqCount), 64'd0);
    chk("e_valid_after_flush", 64'(IssueValid), 64'd0);
    chk("e_free_after_flush",  64'(FreeWable), 64'd0);
    IssueReady = 1'b1;
    repeat (5) tick();
    chk("e_count_settled", 64'(IqCount), 64'd0);
    chk("e_valid_settled", 64'(IssueValid), 64'd0);

    // F: asynchronous reset mid-cycle while an issue and a return are live
    IssueReady = 1'b0;
    alloc(4'd2, 64'hF000_0000_0000_0002, 6'd1,  1'b1, 6'd0, 1'b1);
    alloc(4'd6, 64'hF000_0000_0000_0006, 6'd40, 1'b0, 6'd0, 1'b1);
    tick();
    chk("f_valid_before_rst", 64'(IssueValid), 64'd1);
    chk("f_free_before_rst",  64'(FreeWable),  64'd1);
    chk("f_din_before_rst",   64'(FreeDin),    64'd2);
    chk("f_count_before_rst", 64'(IqCount),    64'd1);
    #2 Rest = 1'b0;
    #1;
    chk("f_valid_in_rst", 64'(IssueValid), 64'd0);
    chk("f_free_in_rst",  64'(FreeWable),  64'd0);
    chk("f_count_in_rst", 64'(IqCount),    64'd0);
    tick();
    Rest = 1'b1;
    IssueReady = 1'b1;
    tick();
    c = cyc;
    exp_iss.push_back('{slot: 4'd2, uop: 64'hF100_0000_0000_0002, cyc: c + 2});
    exp_free.push_back('{slot: 4'd2, uop: 64'd0, cyc: c + 3});
    alloc(4'd2, 64'hF100_0000_0000_0002, 6'd1, 1'b1, 6'd0, 1'b1);
    repeat (5) tick();

    chk("end_issue_queue_empty", 64'(exp_iss.size()),  64'd0);
    chk("end_free_queue_empty",  64'(exp_free.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
